// File: rtl/lane_pipe_chain_pkg.sv
// Shared definitions for the lane pipeline chain.
// Holds the stage/lane index helper macros, the default control-bus payload
// layout and the default per-lane payload width derived from it.

`ifndef LANE_PIPE_CHAIN_PKG_SV
`define LANE_PIPE_CHAIN_PKG_SV

// Flat bit index of (stage, lane) in a stage-major valid vector.
`define LPC_SL_IDX(s, l, lanes) ((s) * (lanes) + (l))
// LSB of lane l inside a packed lanes*width payload vector.
`define LPC_LANE_LSB(l, w) ((l) * (w))

package lane_pipe_chain_pkg;

    localparam int unsigned CTRL_BUS_W = 32;
    localparam int unsigned OPERAND_W  = 32;

    // Issue control word carried alongside each operand.
    typedef struct packed {
        logic [7:0] opcode;
        logic [4:0] rd;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [8:0] flags;
    } ctrl_bus_t;

    // One lane's default payload: control bus plus a 32-bit operand.
    typedef struct packed {
        ctrl_bus_t              ctrl;
        logic [OPERAND_W-1:0]   operand;
    } lane_payload_t;

    localparam int unsigned DEFAULT_DATA_W = $bits(lane_payload_t);

endpackage

`endif

// File: rtl/lane_pipe_chain_if.sv
// Entry/exit bus of the lane pipeline chain.
// in_valid_i/in_data_i/in_ready_o : producer side into stage 0
// out_valid_o/out_data_o           : consumer side from the last stage
// Modport slave is the chain's view, master is the producer/consumer view.

interface lane_pipe_chain_if #(
    parameter int unsigned LANES  = 2,
    parameter int unsigned DATA_W = lane_pipe_chain_pkg::DEFAULT_DATA_W
) ();

    logic [LANES-1:0]        in_valid_i;
    logic [LANES*DATA_W-1:0] in_data_i;
    logic                    in_ready_o;
    logic [LANES-1:0]        out_valid_o;
    logic [LANES*DATA_W-1:0] out_data_o;

    modport slave (
        input  in_valid_i,
        input  in_data_i,
        output in_ready_o,
        output out_valid_o,
        output out_data_o
    );

    modport master (
        output in_valid_i,
        output in_data_i,
        input  in_ready_o,
        input  out_valid_o,
        input  out_data_o
    );

endinterface

// File: rtl/lane_pipe_stage.sv
// One register stage of the lane pipeline chain: LANES valid bits + payloads.
// Ports:
//   clock_i, reset_n_i : clock, synchronous active-low reset
//   flush_i            : clear every lane of this stage
//   keep_i             : per-lane hold of the current entry
//   bubble_i           : per-lane load of an empty slot
//   d_valid_i/d_data_i : source entry (previous stage or chain input)
//   q_valid_o/q_data_o : registered stage contents
// Priority: flush > keep > bubble > load. Invalid slots always carry zero data.

module lane_pipe_stage
    import lane_pipe_chain_pkg::*;
#(
    parameter int unsigned LANES  = 2,
    parameter int unsigned DATA_W = DEFAULT_DATA_W
) (
    input  logic                    clock_i,
    input  logic                    reset_n_i,
    input  logic                    flush_i,
    input  logic [LANES-1:0]        keep_i,
    input  logic [LANES-1:0]        bubble_i,
    input  logic [LANES-1:0]        d_valid_i,
    input  logic [LANES*DATA_W-1:0] d_data_i,
    output logic [LANES-1:0]        q_valid_o,
    output logic [LANES*DATA_W-1:0] q_data_o
);

    always_ff @(posedge clock_i) begin
        if (!reset_n_i || flush_i) begin
            q_valid_o <= '0;
            q_data_o  <= '0;
        end else begin
            for (int unsigned l = 0; l < LANES; l++) begin
                if (!keep_i[l]) begin
                    if (bubble_i[l] || !d_valid_i[l]) begin
                        q_valid_o[l]                                 <= 1'b0;
                        q_data_o[`LPC_LANE_LSB(l, DATA_W) +: DATA_W] <= '0;
                    end else begin
                        q_valid_o[l]                                 <= 1'b1;
                        q_data_o[`LPC_LANE_LSB(l, DATA_W) +: DATA_W] <=
                            d_data_i[`LPC_LANE_LSB(l, DATA_W) +: DATA_W];
                    end
                end
            end
        end
    end

endmodule

// File: rtl/lane_pipe_chain.sv
// Multi-lane, multi-stage pipeline register chain with per-stage stall and
// flush, per-lane split hold at the entry stage and perf counters.
// Ports:
//   clock_i, reset_n_i      : clock, synchronous active-low reset
//   bus (slave)             : in_valid_i/in_data_i/in_ready_o, out_valid_o/out_data_o
//   stall_i, flush_i        : per-stage hold / kill requests
//   lane_hold_i             : per-lane split hold at stage 0
//   stage_valid_o           : valid of stage s lane l at bit s*LANES+l
//   stall_cnt_o/bubble_cnt_o: saturating perf counters
// Macro LANE_PIPE_PERF_CNT_EN enables the counters; otherwise they read 0.

module lane_pipe_chain
    import lane_pipe_chain_pkg::*;
#(
    parameter int unsigned LANES  = 2,
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned DATA_W = DEFAULT_DATA_W,
    parameter int unsigned CNT_W  = 32
) (
    input  logic                     clock_i,
    input  logic                     reset_n_i,
    lane_pipe_chain_if.slave         bus,
    input  logic [DEPTH-1:0]         stall_i,
    input  logic [DEPTH-1:0]         flush_i,
    input  logic [LANES-1:0]         lane_hold_i,
    output logic [DEPTH*LANES-1:0]   stage_valid_o,
    output logic [CNT_W-1:0]         stall_cnt_o,
    output logic [CNT_W-1:0]         bubble_cnt_o
);

    logic [DEPTH-1:0] hold_c;
    logic [DEPTH-1:0] kill_c;
    logic [LANES-1:0] split_hold_c;
    logic             in_ready_c;

    logic [LANES-1:0]        v_q      [DEPTH];
    logic [LANES*DATA_W-1:0] d_q      [DEPTH];
    logic [LANES-1:0]        keep_c   [DEPTH];
    logic [LANES-1:0]        bubble_c [DEPTH];
    logic [LANES-1:0]        src_v_c  [DEPTH];
    logic [LANES*DATA_W-1:0] src_d_c  [DEPTH];

    // A stall freezes its own stage and everything upstream; a flush kills
    // its own stage and everything younger.
    always_comb begin
        hold_c = '0;
        kill_c = '0;
        for (int unsigned s = 0; s < DEPTH; s++) begin
            hold_c[s] = |(stall_i >> s);
            kill_c[s] = |(flush_i >> s);
        end
    end

    // Split hold only acts when stage 0 moves and no flush touches it.
    assign split_hold_c = (!hold_c[0] && !(|flush_i)) ? lane_hold_i : '0;
    assign in_ready_c   = !hold_c[0] && !(|lane_hold_i) && !(|flush_i);

    assign bus.in_ready_o  = in_ready_c;
    assign bus.out_valid_o = v_q[DEPTH-1];
    assign bus.out_data_o  = d_q[DEPTH-1];

    for (genvar s = 0; s < DEPTH; s++) begin : g_stage
        if (s == 0) begin : g_entry
            // Held lanes keep their entry; the rest empty out under a split.
            assign keep_c[s]   = hold_c[0] ? '1 : split_hold_c;
            assign bubble_c[s] = {LANES{|split_hold_c}};
            assign src_v_c[s]  = bus.in_valid_i;
            assign src_d_c[s]  = bus.in_data_i;
        end else begin : g_body
            // A moving stage behind a held one receives a bubble; stage 1
            // also takes a bubble in every split-held lane.
            assign keep_c[s]   = {LANES{hold_c[s]}};
            assign bubble_c[s] = {LANES{hold_c[s-1]}} | ((s == 1) ? split_hold_c : '0);
            assign src_v_c[s]  = v_q[s-1];
            assign src_d_c[s]  = d_q[s-1];
        end

        lane_pipe_stage #(
            .LANES  (LANES),
            .DATA_W (DATA_W)
        ) u_stage (
            .clock_i   (clock_i),
            .reset_n_i (reset_n_i),
            .flush_i   (kill_c[s]),
            .keep_i    (keep_c[s]),
            .bubble_i  (bubble_c[s]),
            .d_valid_i (src_v_c[s]),
            .d_data_i  (src_d_c[s]),
            .q_valid_o (v_q[s]),
            .q_data_o  (d_q[s])
        );

        assign stage_valid_o[`LPC_SL_IDX(s, 0, LANES) +: LANES] = v_q[s];
    end

`ifdef LANE_PIPE_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cnt_q;
    logic [CNT_W-1:0] bubble_cnt_q;

    // Saturating counters: entry not ready, and any exit lane empty.
    always_ff @(posedge clock_i) begin
        if (!reset_n_i) begin
            stall_cnt_q  <= '0;
            bubble_cnt_q <= '0;
        end else begin
            if (!in_ready_c && (stall_cnt_q != '1)) begin
                stall_cnt_q <= stall_cnt_q + CNT_W'(1);
            end
            if (!(&v_q[DEPTH-1]) && (bubble_cnt_q != '1)) begin
                bubble_cnt_q <= bubble_cnt_q + CNT_W'(1);
            end
        end
    end

    assign stall_cnt_o  = stall_cnt_q;
    assign bubble_cnt_o = bubble_cnt_q;
`else
    assign stall_cnt_o  = '0;
    assign bubble_cnt_o = '0;
`endif

endmodule

// File: tb/tb_lane_pipe_chain.sv
// Self-checking bench for lane_pipe_chain (LANES=2, DEPTH=4, DATA_W=32, CNT_W=4).
// Expected values come from a stage-by-stage behavioural model of the
// hold/flush/split rules, plus fixed expectations for the directed scenarios.

module tb_lane_pipe_chain;

    localparam int unsigned LANES   = 2;
    localparam int unsigned DEPTH   = 4;
    localparam int unsigned DATA_W  = 32;
    localparam int unsigned CNT_W   = 4;
    localparam int unsigned CNT_MAX = (1 << CNT_W) - 1;

    logic                     clock_i = 1'b0;
    logic                     reset_n_i;
    logic [DEPTH-1:0]         stall_i;
    logic [DEPTH-1:0]         flush_i;
    logic [LANES-1:0]         lane_hold_i;
    logic [DEPTH*LANES-1:0]   stage_valid_o;
    logic [CNT_W-1:0]         stall_cnt_o;
    logic [CNT_W-1:0]         bubble_cnt_o;

    int n_cmp = 0;
    int n_err = 0;

    // Behavioural model state.
    logic [LANES-1:0]  mv [DEPTH];
    logic [DATA_W-1:0] md [DEPTH][LANES];
    int unsigned       m_stall;
    int unsigned       m_bubble;

    lane_pipe_chain_if #(.LANES(LANES), .DATA_W(DATA_W)) bus ();

    lane_pipe_chain #(
        .LANES  (LANES),
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W),
        .CNT_W  (CNT_W)
    ) dut (
        .clock_i       (clock_i),
        .reset_n_i     (reset_n_i),
        .bus           (bus),
        .stall_i       (stall_i),
        .flush_i       (flush_i),
        .lane_hold_i   (lane_hold_i),
        .stage_valid_o (stage_valid_o),
        .stall_cnt_o   (stall_cnt_o),
        .bubble_cnt_o  (bubble_cnt_o)
    );

    always #5 clock_i = ~clock_i;

    function automatic logic exp_ready();
        return (stall_i == '0) && (lane_hold_i == '0) && (flush_i == '0);
    endfunction

    function automatic logic [DEPTH*LANES-1:0] exp_sv();
        logic [DEPTH*LANES-1:0] r;
        for (int s = 0; s < DEPTH; s++)
            for (int l = 0; l < LANES; l++)
                r[s*LANES+l] = mv[s][l];
        return r;
    endfunction

    function automatic logic [LANES*DATA_W-1:0] exp_od();
        return {md[DEPTH-1][1], md[DEPTH-1][0]};
    endfunction

    // Advance the model by one edge using the inputs now applied, then wait
    // for the DUT edge and settle 1 time unit past it.
    task automatic tick();
        logic [LANES-1:0]  nv [DEPTH];
        logic [DATA_W-1:0] nd [DEPTH][LANES];
        bit held, fl, prev_held;
        for (int s = 0; s < DEPTH; s++) begin
            held      = (stall_i >> s) != 0;
            fl        = (flush_i >> s) != 0;
            prev_held = (s > 0) && ((stall_i >> (s - 1)) != 0);
            for (int l = 0; l < LANES; l++) begin
                nv[s][l] = 1'b0;
                nd[s][l] = '0;
                if (!reset_n_i || fl) begin
                    nv[s][l] = 1'b0;
                end else if (held) begin
                    nv[s][l] = mv[s][l];
                    nd[s][l] = md[s][l];
                end else if (s == 0) begin
                    if (lane_hold_i != 0) begin
                        if (lane_hold_i[l]) begin
                            nv[s][l] = mv[s][l];
                            nd[s][l] = md[s][l];
                        end
                    end else if (bus.in_valid_i[l]) begin
                        nv[s][l] = 1'b1;
                        nd[s][l] = bus.in_data_i[l*DATA_W +: DATA_W];
                    end
                end else if (!prev_held &&
                             !(s == 1 && lane_hold_i[l] && flush_i == 0)) begin
                    nv[s][l] = mv[s-1][l];
                    nd[s][l] = md[s-1][l];
                end
            end
        end
        if (!reset_n_i) begin
            m_stall  = 0;
            m_bubble = 0;
        end else begin
`ifdef LANE_PIPE_PERF_CNT_EN
            if (!exp_ready() && m_stall < CNT_MAX) m_stall++;
            if (mv[DEPTH-1] != '1 && m_bubble < CNT_MAX) m_bubble++;
`endif
        end
        @(posedge clock_i);
        #1;
        mv = nv;
        md = nd;
    endtask

    task automatic set_idle();
        bus.in_valid_i = '0;
        bus.in_data_i  = '0;
        stall_i        = '0;
        flush_i        = '0;
        lane_hold_i    = '0;
    endtask

    task automatic test_reset();
        set_idle();
        reset_n_i = 1'b0;
        tick();
        tick();
        reset_n_i = 1'b1;
        #1;
        n_cmp++; if (stage_valid_o !== '0) begin n_err++; $display("FAIL reset_stage_valid: got %h exp 0", stage_valid_o); end
        n_cmp++; if (bus.out_valid_o !== '0) begin n_err++; $display("FAIL reset_out_valid: got %b exp 0", bus.out_valid_o); end
        n_cmp++; if (bus.out_data_o !== '0) begin n_err++; $display("FAIL reset_out_data: got %h exp 0", bus.out_data_o); end
        n_cmp++; if (bus.in_ready_o !== 1'b1) begin n_err++; $display("FAIL reset_in_ready: got %b exp 1", bus.in_ready_o); end
        n_cmp++; if ({stall_cnt_o, bubble_cnt_o} !== '0) begin n_err++; $display("FAIL reset_counters: got %h/%h exp 0/0", stall_cnt_o, bubble_cnt_o); end
    endtask

    task automatic test_streaming();
        for (int g = 0; g < 10; g++) begin
            bus.in_valid_i = (g < 6) ? 2'b11 : 2'b00;
            bus.in_data_i  = {32'(32'h22 + 32'h22 * g), 32'(32'h11 + 32'h22 * g)};
            #1;
            n_cmp++; if (bus.in_ready_o !== 1'b1) begin n_err++; $display("FAIL stream_ready: got %b exp 1", bus.in_ready_o); end
            tick();
            n_cmp++;
            if ({stage_valid_o, bus.out_valid_o, bus.out_data_o} !== {exp_sv(), mv[DEPTH-1], exp_od()}) begin
                n_err++;
                $display("FAIL stream_state g=%0d: got %h/%b/%h exp %h/%b/%h", g, stage_valid_o,
                         bus.out_valid_o, bus.out_data_o, exp_sv(), mv[DEPTH-1], exp_od());
            end
            if (g == 3) begin
                n_cmp++;
                if ({bus.out_valid_o, bus.out_data_o} !== {2'b11, 32'h22, 32'h11}) begin
                    n_err++; $display("FAIL stream_first_out: got %b/%h exp 11/0000002200000011", bus.out_valid_o, bus.out_data_o);
                end
            end
            if (g == 4) begin
                n_cmp++;
                if ({bus.out_valid_o, bus.out_data_o} !== {2'b11, 32'h44, 32'h33}) begin
                    n_err++; $display("FAIL stream_second_out: got %b/%h exp 11/0000004400000033", bus.out_valid_o, bus.out_data_o);
                end
            end
        end
        set_idle();
    endtask

    task automatic test_stall();
        logic [LANES*DATA_W-1:0] q[$];
        logic [LANES*DATA_W-1:0] exp_grp;
        int k = 0;
        for (int c = 0; c < 13; c++) begin
            bus.in_valid_i = (c < 8) ? 2'b11 : 2'b00;
            bus.in_data_i  = {32'(32'h1001 + 2 * k), 32'(32'h1000 + 2 * k)};
            stall_i        = (c == 4 || c == 5) ? 4'b0100 : 4'b0000;
            #1;
            if (c == 4 || c == 5) begin
                n_cmp++; if (bus.in_ready_o !== 1'b0) begin n_err++; $display("FAIL stall_ready c=%0d: got %b exp 0", c, bus.in_ready_o); end
            end
            if (exp_ready() && bus.in_valid_i == 2'b11) begin
                q.push_back(bus.in_data_i);
                k++;
            end
            tick();
            n_cmp++;
            if ({stage_valid_o, bus.out_data_o} !== {exp_sv(), exp_od()}) begin
                n_err++; $display("FAIL stall_state c=%0d: got %h/%h exp %h/%h", c, stage_valid_o, bus.out_data_o, exp_sv(), exp_od());
            end
            if (c == 4) begin
                n_cmp++; if (stage_valid_o[7:6] !== 2'b00) begin n_err++; $display("FAIL stall_stage3_bubble: got %b exp 00", stage_valid_o[7:6]); end
            end
            if (bus.out_valid_o != 0) begin
                exp_grp = (q.size() > 0) ? q.pop_front() : 'x;
                n_cmp++;
                if (bus.out_data_o !== exp_grp) begin
                    n_err++; $display("FAIL stall_order c=%0d: got %h exp %h", c, bus.out_data_o, exp_grp);
                end
            end
        end
        n_cmp++; if (q.size() != 0) begin n_err++; $display("FAIL stall_lost: got %0d left exp 0", q.size()); end
        set_idle();
    endtask

    task automatic test_flush();
        for (int c = 0; c < 4; c++) begin
            bus.in_valid_i = 2'b11;
            bus.in_data_i  = {32'(32'h2001 + 2 * c), 32'(32'h2000 + 2 * c)};
            tick();
        end
        flush_i = 4'b0100;
        stall_i = 4'b0100;
        #1;
        n_cmp++; if (bus.in_ready_o !== 1'b0) begin n_err++; $display("FAIL flush_ready: got %b exp 0", bus.in_ready_o); end
        n_cmp++;
        if ({bus.out_valid_o, bus.out_data_o} !== {2'b11, 32'h2001, 32'h2000}) begin
            n_err++; $display("FAIL flush_retire: got %b/%h exp 11/0000200100002000", bus.out_valid_o, bus.out_data_o);
        end
        tick();
        n_cmp++; if (stage_valid_o !== 8'h00) begin n_err++; $display("FAIL flush_cleared: got %h exp 00", stage_valid_o); end
        n_cmp++; if (stage_valid_o !== exp_sv()) begin n_err++; $display("FAIL flush_model: got %h exp %h", stage_valid_o, exp_sv()); end
        set_idle();
        tick();
    endtask

    task automatic test_split_hold();
        bus.in_valid_i = 2'b11;
        bus.in_data_i  = {32'hA1, 32'hA0};
        tick();
        bus.in_data_i  = {32'hEF, 32'hEE};
        lane_hold_i    = 2'b01;
        #1;
        n_cmp++; if (bus.in_ready_o !== 1'b0) begin n_err++; $display("FAIL split_ready: got %b exp 0", bus.in_ready_o); end
        tick();
        n_cmp++; if (stage_valid_o !== 8'b0000_1001) begin n_err++; $display("FAIL split_hold_cycle: got %b exp 00001001", stage_valid_o); end
        set_idle();
        tick();
        n_cmp++; if (stage_valid_o !== 8'b0010_0100) begin n_err++; $display("FAIL split_release: got %b exp 00100100", stage_valid_o); end
        tick();
        n_cmp++;
        if ({bus.out_valid_o, bus.out_data_o} !== {2'b10, 32'hA1, 32'h0}) begin
            n_err++; $display("FAIL split_out_a1: got %b/%h exp 10/000000a100000000", bus.out_valid_o, bus.out_data_o);
        end
        tick();
        n_cmp++;
        if ({bus.out_valid_o, bus.out_data_o} !== {2'b01, 32'h0, 32'hA0}) begin
            n_err++; $display("FAIL split_out_a0: got %b/%h exp 01/00000000000000a0", bus.out_valid_o, bus.out_data_o);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        for (int c = 0; c < 4; c++) begin
            bus.in_valid_i = 2'b11;
            bus.in_data_i  = {32'(32'h3001 + 2 * c), 32'(32'h3000 + 2 * c)};
            tick();
        end
        reset_n_i = 1'b0;
        tick();
        n_cmp++;
        if ({stage_valid_o, bus.out_valid_o, bus.out_data_o, bus.in_ready_o} !== {8'h00, 2'b00, 64'h0, 1'b1}) begin
            n_err++; $display("FAIL midreset_clear: got %h/%b/%h/%b exp 00/00/0/1", stage_valid_o, bus.out_valid_o, bus.out_data_o, bus.in_ready_o);
        end
        reset_n_i      = 1'b1;
        bus.in_data_i  = {32'hBEEF0002, 32'hBEEF0001};
        tick();
        set_idle();
        for (int c = 0; c < 3; c++) tick();
        n_cmp++;
        if ({bus.out_valid_o, bus.out_data_o} !== {2'b11, 32'hBEEF0002, 32'hBEEF0001}) begin
            n_err++; $display("FAIL midreset_exit: got %b/%h exp 11/beef0002beef0001", bus.out_valid_o, bus.out_data_o);
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            reset_n_i      = ($urandom_range(0, 99) < 2) ? 1'b0 : 1'b1;
            bus.in_valid_i = LANES'($urandom);
            bus.in_data_i  = {$urandom, $urandom};
            for (int s = 0; s < DEPTH; s++) begin
                stall_i[s] = ($urandom_range(0, 99) < 12);
                flush_i[s] = ($urandom_range(0, 99) < 4);
            end
            for (int l = 0; l < LANES; l++) lane_hold_i[l] = ($urandom_range(0, 99) < 10);
            #1;
            n_cmp++; if (bus.in_ready_o !== exp_ready()) begin n_err++; $display("FAIL rand_ready c=%0d: got %b exp %b", c, bus.in_ready_o, exp_ready()); end
            tick();
            n_cmp++;
            if ({stage_valid_o, bus.out_valid_o, bus.out_data_o, stall_cnt_o, bubble_cnt_o} !==
                {exp_sv(), mv[DEPTH-1], exp_od(), CNT_W'(m_stall), CNT_W'(m_bubble)}) begin
                n_err++;
                $display("FAIL rand_state c=%0d: got %h/%b/%h/%h/%h exp %h/%b/%h/%h/%h", c, stage_valid_o, bus.out_valid_o,
                         bus.out_data_o, stall_cnt_o, bubble_cnt_o, exp_sv(), mv[DEPTH-1], exp_od(),
                         CNT_W'(m_stall), CNT_W'(m_bubble));
            end
        end
        reset_n_i = 1'b1;
        set_idle();
    endtask

    task automatic test_counters();
        logic [CNT_W-1:0] exp_sat;
`ifdef LANE_PIPE_PERF_CNT_EN
        exp_sat = 4'hF;
`else
        exp_sat = 4'h0;
`endif
        reset_n_i = 1'b0;
        tick();
        reset_n_i = 1'b1;
        stall_i   = 4'b0001;
        for (int c = 0; c < 20; c++) begin
            bus.in_valid_i = LANES'($urandom);
            bus.in_data_i  = {$urandom, $urandom};
            tick();
            n_cmp++;
            if ({stall_cnt_o, bubble_cnt_o} !== {CNT_W'(m_stall), CNT_W'(m_bubble)}) begin
                n_err++; $display("FAIL cnt_track c=%0d: got %h/%h exp %h/%h", c, stall_cnt_o, bubble_cnt_o, CNT_W'(m_stall), CNT_W'(m_bubble));
            end
        end
        n_cmp++; if (stall_cnt_o !== exp_sat) begin n_err++; $display("FAIL cnt_stall_sat: got %h exp %h", stall_cnt_o, exp_sat); end
        n_cmp++; if (bubble_cnt_o !== exp_sat) begin n_err++; $display("FAIL cnt_bubble_sat: got %h exp %h", bubble_cnt_o, exp_sat); end
        set_idle();
    endtask

    initial begin
        for (int s = 0; s < DEPTH; s++) begin
            mv[s] = '0;
            for (int l = 0; l < LANES; l++) md[s][l] = '0;
        end
        m_stall   = 0;
        m_bubble  = 0;
        reset_n_i = 1'b0;
        set_idle();
        #2;
        test_reset();
        test_streaming();
        test_stall();
        test_flush();
        test_split_hold();
        test_reset_mid();
        test_random();
        test_counters();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
